// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: shifts a pattern in, runs one capture cycle, then unloads the response.
// Optional MISR signature over the unload stream is enabled by defining SCAN_CHAIN_CTRL_MISR_EN.
module scan_chain_ctrl #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned LW      = $clog2(MAX_LEN + 1)
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   ,
   parameter int unsigned SIG_W        = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [LW-1:0]      LEN,
   input  logic [MAX_LEN-1:0] PAT,
   input  logic               ABORT,
   input  logic               SO,
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   input  logic               SIG_CLR,
   output logic [SIG_W-1:0]   SIG,
`endif
   output logic               SE,
   output logic               SI,
   output logic               BUSY,
   output logic [MAX_LEN-1:0] RSP,
   output logic               RSP_VALID,
   output logic               ERR
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SHIFT   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] UNLOAD  = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]         state, state_d;
   logic [LW-1:0]      cnt, cnt_d;
   logic [LW-1:0]      len_q, len_d;
   logic [MAX_LEN-1:0] pat_sh, pat_sh_d;
   logic [MAX_LEN-1:0] rsp_sh, rsp_sh_d;
   logic [MAX_LEN-1:0] rsp_d;
   logic [MAX_LEN-1:0] aligned;
   logic               se_d, si_d, busy_d, valid_d, err_d;
   logic               last;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   logic [SIG_W-1:0]   sig_d;
`endif

   // Next state plus next values of every registered output
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      len_d    = len_q;
      pat_sh_d = pat_sh;
      rsp_sh_d = rsp_sh;
      rsp_d    = RSP;
      err_d    = ERR;
      se_d     = 1'b0;
      si_d     = 1'b0;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
      last     = (cnt == len_q - LW'(1));
      // Left-justify the pattern so bit LEN-1 sits at the MSB and leaves first
      aligned  = PAT << (LW'(MAX_LEN) - LEN);
`ifdef SCAN_CHAIN_CTRL_MISR_EN
      sig_d    = SIG;
`endif
      case (state)
         IDLE: begin
            busy_d = 1'b0;
            if (START) begin
               busy_d = 1'b1;
               if (LEN != '0 && LEN <= LW'(MAX_LEN)) begin
                  state_d  = SHIFT;
                  cnt_d    = '0;
                  len_d    = LEN;
                  err_d    = 1'b0;
                  rsp_sh_d = '0;
                  se_d     = 1'b1;
                  si_d     = aligned[MAX_LEN-1];
                  pat_sh_d = aligned << 1;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            if (ABORT) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (last) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d    = cnt + LW'(1);
               se_d     = 1'b1;
               si_d     = pat_sh[MAX_LEN-1];
               pat_sh_d = pat_sh << 1;
            end
         end
         CAPTURE: begin
            if (ABORT) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = UNLOAD;
               cnt_d   = '0;
               se_d    = 1'b1;
            end
         end
         UNLOAD: begin
            if (ABORT) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               // SO arrives from position LEN-1 downward, so shifting left lands it in order
               rsp_sh_d = {rsp_sh[MAX_LEN-2:0], SO};
`ifdef SCAN_CHAIN_CTRL_MISR_EN
               sig_d = ({SIG[SIG_W-2:0], 1'b0} ^ (SIG[SIG_W-1] ? SIG_POLY : '0))
                       ^ {{(SIG_W-1){1'b0}}, SO};
`endif
               if (last) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt + LW'(1);
                  se_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            if (!ERR) rsp_d = rsp_sh;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
`ifdef SCAN_CHAIN_CTRL_MISR_EN
      if (SIG_CLR) sig_d = '0;
`endif
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         len_q     <= '0;
         pat_sh    <= '0;
         rsp_sh    <= '0;
         RSP       <= '0;
         SE        <= 1'b0;
         SI        <= 1'b0;
         BUSY      <= 1'b0;
         RSP_VALID <= 1'b0;
         ERR       <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         SIG       <= '0;
`endif
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         len_q     <= len_d;
         pat_sh    <= pat_sh_d;
         rsp_sh    <= rsp_sh_d;
         RSP       <= rsp_d;
         SE        <= se_d;
         SI        <= si_d;
         BUSY      <= busy_d;
         RSP_VALID <= valid_d;
         ERR       <= err_d;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         SIG       <= sig_d;
`endif
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a scan-chain model on SE/SI/SO, a cycle-indexed reference model
// checked every cycle, and directed requests with hand-computed results.
module tb_scan_chain_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort, so;
   logic [6:0]  len;
   logic [63:0] pat;
   logic        se, si, busy, rsp_valid, err;
   logic [63:0] rsp;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   logic        sig_clr = 1'b0;
   logic [15:0] sig;
   logic [15:0] m_sig = '0;
`endif

   scan_chain_ctrl dut (
      .CLK(clk), .RST(rst), .START(start), .LEN(len), .PAT(pat), .ABORT(abort), .SO(so),
`ifdef SCAN_CHAIN_CTRL_MISR_EN
      .SIG_CLR(sig_clr), .SIG(sig),
`endif
      .SE(se), .SI(si), .BUSY(busy), .RSP(rsp), .RSP_VALID(rsp_valid), .ERR(err)
   );

   always #5 clk = ~clk;

   // Scan chain: shift when SE, else capture D = Q (loopback) or D = ~Q
   logic [63:0] chain = '0;
   logic [5:0]  so_idx = '0;
   logic        inv_mode = 1'b0;
   assign so = chain[so_idx];
   always @(posedge clk) begin
      if (se) chain <= {chain[62:0], si};
      else    chain <= inv_mode ? ~chain : chain;
   end

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_rsp(input logic [63:0] p, input int l, input bit inv);
      logic [63:0] mask;
      mask = (l >= 64) ? '1 : ((64'd1 << l) - 64'd1);
      return (inv ? ~p : p) & mask;
   endfunction

`ifdef SCAN_CHAIN_CTRL_MISR_EN
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
      return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {15'd0, b};
   endfunction
`endif

   // Reference model: k counts cycles since the accepting edge; shift k=1..L,
   // capture L+1, unload L+2..2L+1, done 2L+2 (done at k=1 for an illegal LEN)
   bit          m_active = 1'b0, m_err = 1'b0, m_valid = 1'b0;
   int          m_k = 0, m_len = 0, m_done_k = 0;
   logic [63:0] m_pat = '0, m_rsp = '0, m_exp = '0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_active = 1'b0; m_err = 1'b0; m_valid = 1'b0; m_rsp = '0; m_k = 0;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         m_sig = '0;
`endif
      end else begin
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         if (sig_clr) m_sig = '0;
         else if (m_active && !m_err && !abort && m_k >= m_len + 2 && m_k <= 2 * m_len + 1)
            m_sig = misr_step(m_sig, m_exp[2 * m_len + 1 - m_k]);
`endif
         if (!m_active) begin
            m_valid = 1'b0;
            if (start) begin
               m_active = 1'b1;
               m_k = 1;
               if (int'(len) >= 1 && int'(len) <= 64) begin
                  m_len = int'(len); m_pat = pat; m_err = 1'b0;
                  m_done_k = 2 * m_len + 2;
                  m_exp = exp_rsp(pat, m_len, inv_mode);
               end else begin
                  m_len = 0; m_err = 1'b1; m_done_k = 1;
               end
            end
         end else if (m_k == m_done_k) begin
            m_active = 1'b0;
            m_valid = 1'b1;
            if (!m_err) m_rsp = m_exp;
         end else if (abort) begin
            m_active = 1'b0;
         end else begin
            m_k++;
         end
      end
   end

   // Every-cycle comparison against the model
   initial forever begin
      logic e_se, e_si;
      @(negedge clk);
      if (chk_en) begin
         e_se = m_active && (m_k <= m_len || (m_k >= m_len + 2 && m_k <= 2 * m_len + 1));
         e_si = (m_active && m_k <= m_len) ? m_pat[m_len - m_k] : 1'b0;
         chk("cyc_se", 64'(se), 64'(e_se));
         chk("cyc_si", 64'(si), 64'(e_si));
         chk("cyc_busy", 64'(busy), 64'(m_active));
         chk("cyc_valid", 64'(rsp_valid), 64'(m_valid));
         chk("cyc_err", 64'(err), 64'(m_err));
         chk("cyc_rsp", rsp, m_rsp);
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         chk("cyc_sig", 64'(sig), 64'(m_sig));
`endif
      end
   end

   // One request; caller sits 1 time unit after a rising edge.
   // inj_kind: 1=START, 2=ABORT, 3=RST, 4=SIG_CLR, driven during cycle inj_k.
   task automatic run_req(input int l, input logic [63:0] p, input bit inv, input int inj_k,
                          input int inj_kind, input bit abort_with_start, output int vk,
                          output logic [63:0] rsp_o, output logic [63:0] si_seq,
                          output logic [63:0] se_seq);
      inv_mode = inv;
      so_idx   = (l >= 1 && l <= 64) ? 6'(l - 1) : 6'd0;
      start = 1'b1; len = 7'(l); pat = p; abort = abort_with_start;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      vk = 0; rsp_o = '0; si_seq = '0; se_seq = '0;
      for (int i = 1; i <= 2 * l + 12; i++) begin
         if (i == inj_k) begin
            case (inj_kind)
               1: start = 1'b1;
               2: abort = 1'b1;
               3: rst = 1'b1;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
               4: sig_clr = 1'b1;
`endif
               default: ;
            endcase
         end
         @(negedge clk);
         se_seq = {se_seq[62:0], se};
         if (se && i <= l) si_seq = {si_seq[62:0], si};
         if (rsp_valid && vk == 0) begin
            vk = i;
            rsp_o = rsp;
         end
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         if (inj_kind == 4 && i == inj_k + 1) chk("sigclr_in_unload", 64'(sig), 64'd0);
`endif
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0; rst = 1'b0;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
         sig_clr = 1'b0;
`endif
      end
   endtask

   int          vk;
   logic [63:0] r, si_s, se_s;
   logic [63:0] big = 64'hDEADBEEF_01234567;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; pat = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_ctrl", {59'd0, se, si, busy, rsp_valid, err}, 64'd0);
      chk("reset_rsp", rsp, 64'd0);
      @(posedge clk); #1;

      // loopback A5: SI order 1,0,1,0,0,1,0,1 and RSP back unchanged
      run_req(8, 64'hA5, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("a5_si_order", {56'd0, si_s[7:0]}, 64'hA5);
      chk("a5_latency", 64'(vk - 1), 64'd18);
      chk("a5_rsp", r, 64'hA5);

      // reset during shift cycle 3
      run_req(8, 64'h3C, 1'b0, 3, 3, 1'b0, vk, r, si_s, se_s);
      chk("rst_no_valid", 64'(vk), 64'd0);
      chk("rst_se_trace", {36'd0, se_s[27:0]}, 64'hE000000);
      chk("rst_rsp", rsp, 64'd0);

      // capture through inverting D, one SE-low cycle between bursts
      run_req(4, 64'h3, 1'b1, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("inv_rsp", r, 64'hC);
      chk("inv_se_gap", {44'd0, se_s[19:0]}, 64'hF7800);

      run_req(1, 64'h1, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("len1_latency", 64'(vk - 1), 64'd4);
      chk("len1_rsp", r, 64'h1);

      run_req(64, big, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("lenmax_latency", 64'(vk - 1), 64'd130);
      chk("lenmax_rsp", r, big);

      // illegal lengths: error flag, quick RSP_VALID, no chain activity, RSP kept
      run_req(0, 64'hFF, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("len0_valid_cycle", 64'(vk), 64'd2);
      chk("len0_se_never", se_s, 64'd0);
      chk("len0_err", 64'(err), 64'd1);
      chk("len0_rsp_kept", rsp, big);
      run_req(100, 64'hFF, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("len100_valid_cycle", 64'(vk), 64'd2);
      chk("len100_err", 64'(err), 64'd1);

      // START during UNLOAD cycle 2 is ignored
      run_req(8, 64'h5A, 1'b1, 11, 1, 1'b0, vk, r, si_s, se_s);
      chk("busy_start_latency", 64'(vk - 1), 64'd18);
      chk("busy_start_rsp", r, 64'hA5);
      chk("err_cleared", 64'(err), 64'd0);
      chk("busy_start_idle", 64'(busy), 64'd0);

      // ABORT during UNLOAD cycle 2
      run_req(8, 64'h3C, 1'b0, 11, 2, 1'b0, vk, r, si_s, se_s);
      chk("abort_no_valid", 64'(vk), 64'd0);
      chk("abort_se_trace", {36'd0, se_s[27:0]}, 64'hFF60000);
      chk("abort_rsp_kept", rsp, 64'hA5);

      // clean request afterwards, with ABORT alongside START (START wins)
      run_req(8, 64'h3C, 1'b0, 0, 0, 1'b1, vk, r, si_s, se_s);
      chk("post_abort_latency", 64'(vk - 1), 64'd18);
      chk("post_abort_rsp", r, 64'h3C);

`ifdef SCAN_CHAIN_CTRL_MISR_EN
      sig_clr = 1'b1;
      @(posedge clk); #1;
      sig_clr = 1'b0;
      chk("sig_cleared", 64'(sig), 64'd0);
      run_req(8, 64'hA5, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      run_req(8, 64'h3C, 1'b0, 0, 0, 1'b0, vk, r, si_s, se_s);
      chk("misr_rsp", r, 64'h3C);
      run_req(8, 64'hA5, 1'b0, 11, 4, 1'b0, vk, r, si_s, se_s);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
